// File: rtl/serial_adder_n.sv
// -----------------------------------------------------------------------------
// serial_adder_n
//   Bit-serial adder: one full-adder cell is reused over WIDTH clock cycles to
//   add two WIDTH-bit operands plus a carry-in, LSB first. A start/busy/done
//   handshake frames each operation. The sum, carry-out and signed-overflow
//   results live in output registers, so they hold steady between operations.
//
// Parameters
//   WIDTH     operand/sum width in bits, 1..64 (default 8)
//
// Ports
//   clk       system clock, rising-edge active
//   rst       asynchronous active-high reset
//   start     request a new addition (accepted in IDLE or DONE)
//   a, b      WIDTH-bit operands, sampled only on the accepting edge
//   cin       carry-in, sampled only on the accepting edge
//   busy      high while bits are being processed
//   done      one-cycle pulse after the result registers update
//   sum       registered (a + b + cin) mod 2^WIDTH
//   cout      registered carry out of bit WIDTH-1
//   overflow  registered signed overflow (carry into MSB ^ carry out of MSB)
// -----------------------------------------------------------------------------
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  // The bit counter needs at least one bit even when WIDTH=1 (it is then idle).
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] acc_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic             load_s;
  logic             step_s;
  logic             last_s;
  logic             bit_s;
  logic             carry_nxt_s;
  logic [WIDTH-1:0] acc_nxt_s;

  // Sum output of the shared full-adder cell.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // Carry output of the shared full-adder cell (majority of the three inputs).
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  // Full-adder slice on the current LSBs and the accumulator shift-in value.
  always_comb begin
    bit_s       = fa_sum(sa_r[0], sb_r[0], carry_r);
    carry_nxt_s = fa_carry(sa_r[0], sb_r[0], carry_r);
    // New sum bit enters at the MSB; after WIDTH shifts bit i is sum bit i.
    acc_nxt_s   = (acc_r >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
    if (cnt_r == LAST_BIT) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        // Accepting here gives back-to-back operation without an IDLE gap.
        if (start) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus busy/done flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
    end
  end

  // Operand shift registers, carry, bit counter, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_r    <= {WIDTH{1'b0}};
      sb_r    <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (load_s) begin
      sa_r    <= a;
      sb_r    <= b;
      carry_r <= cin;
      cnt_r   <= {CW{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
    end else if (step_s) begin
      sa_r    <= sa_r >> 1;
      sb_r    <= sb_r >> 1;
      carry_r <= carry_nxt_s;
      acc_r   <= acc_nxt_s;
      if (last_s) begin
        // Counter parks at WIDTH-1; carry_r is the carry entering the MSB here.
        cnt_r  <= cnt_r;
        sum_r  <= acc_nxt_s;
        cout_r <= carry_nxt_s;
        ovf_r  <= carry_r ^ carry_nxt_s;
      end else begin
        cnt_r  <= cnt_r + CW'(1);
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign sum      = sum_r;
  assign cout     = cout_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_serial_adder_n.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_n
//   Scoreboard bench for serial_adder_n with WIDTH=8, WIDTH=4 and WIDTH=1
//   instances. Stimulus pushes the expected result and the expected done cycle
//   into a per-instance queue; a negedge monitor pops and compares on done.
// -----------------------------------------------------------------------------
module tb_serial_adder_n;

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    int          cyc;
  } exp_t;

  logic       clk;
  logic       rst;

  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;
  logic       start1, cin1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;

  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;
  exp_t q8[$];
  exp_t q4[$];
  exp_t q1[$];

  // Back-to-back vectors with hand-computed results.
  logic [7:0] bb_a[4]  = '{8'd10, 8'd200, 8'd64,  8'd255};
  logic [7:0] bb_b[4]  = '{8'd20, 8'd100, 8'd64,  8'd255};
  logic       bb_c[4]  = '{1'b0,  1'b0,   1'b0,   1'b1};
  logic [7:0] bb_s[4]  = '{8'd30, 8'd44,  8'd128, 8'd255};
  logic       bb_co[4] = '{1'b0,  1'b1,   1'b0,   1'b1};
  logic       bb_ov[4] = '{1'b0,  1'b0,   1'b1,   1'b0};

  serial_adder_n #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );
  serial_adder_n #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
  );
  serial_adder_n #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [63:0] s, input logic co, input logic ov);
    exp_t e;
    e.s = s; e.co = co; e.ov = ov; e.cyc = 0;
    return e;
  endfunction

  // Reference: whole-word add; carry into the MSB from the low WIDTH-1 bits.
  function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y, input logic c);
    exp_t e;
    logic [63:0] m, lm, full, low;
    m    = (64'd1 << w) - 64'd1;
    lm   = (64'd1 << (w - 1)) - 64'd1;
    full = (x & m) + (y & m) + {63'd0, c};
    low  = (x & lm) + (y & lm) + {63'd0, c};
    e.s   = full & m;
    e.co  = full[w];
    e.ov  = low[w-1] ^ full[w];
    e.cyc = 0;
    return e;
  endfunction

  // Present operands with start high; accepted on the next edge.
  task automatic issue(input int w, input logic [63:0] x, input logic [63:0] y, input logic c, input exp_t e);
    e.cyc = cyc + 1 + w;
    case (w)
      8: begin a8 = x[7:0]; b8 = y[7:0]; cin8 = c; start8 = 1'b1; q8.push_back(e); end
      4: begin a4 = x[3:0]; b4 = y[3:0]; cin4 = c; start4 = 1'b1; q4.push_back(e); end
      default: begin a1 = x[0:0]; b1 = y[0:0]; cin1 = c; start1 = 1'b1; q1.push_back(e); end
    endcase
  endtask

  task automatic stop(input int w);
    case (w)
      8: start8 = 1'b0;
      4: start4 = 1'b0;
      default: start1 = 1'b0;
    endcase
  endtask

  task automatic wait_done(input int w);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (w == 8) ? done8 : (w == 4) ? done4 : done1;
    end
    if (!seen) begin
      total++;
      $display("FAIL w%0d_timeout: done=0 after 40 cycles, required done=1", w);
    end
  endtask

  task automatic op(input int w, input logic [63:0] x, input logic [63:0] y, input logic c, input exp_t e);
    issue(w, x, y, c, e);
    @(posedge clk); #1;
    stop(w);
    wait_done(w);
  endtask

  task automatic mon(input int w, input logic [63:0] s, input logic co, input logic ov, input logic bz);
    exp_t e;
    int   n;
    n = (w == 8) ? q8.size() : (w == 4) ? q4.size() : q1.size();
    if (n == 0) begin
      total++;
      $display("FAIL w%0d_unexpected_done: done=1 at cycle %0d, required no done", w, cyc);
    end else begin
      case (w)
        8: e = q8.pop_front();
        4: e = q4.pop_front();
        default: e = q1.pop_front();
      endcase
      chk($sformatf("w%0d_sum", w), s, e.s);
      chk($sformatf("w%0d_cout", w), {63'd0, co}, {63'd0, e.co});
      chk($sformatf("w%0d_overflow", w), {63'd0, ov}, {63'd0, e.ov});
      chk($sformatf("w%0d_done_cycle", w), 64'(cyc), 64'(e.cyc));
      chk($sformatf("w%0d_busy_in_done", w), {63'd0, bz}, 64'd0);
    end
  endtask

  // Scoreboard monitors, sampled away from the active edge.
  always @(negedge clk) if (done8 === 1'b1) mon(8, 64'(sum8), cout8, ovf8, busy8);
  always @(negedge clk) if (done4 === 1'b1) mon(4, 64'(sum4), cout4, ovf4, busy4);
  always @(negedge clk) if (done1 === 1'b1) mon(1, 64'(sum1), cout1, ovf1, busy1);

  initial begin
    bit         seen;
    logic [2:0] v3;
    rst = 1'b0;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("reset_sum", 64'(sum8), 64'd0);
    chk("reset_cout", {63'd0, cout8}, 64'd0);
    chk("reset_overflow", {63'd0, ovf8}, 64'd0);
    chk("reset_busy", {63'd0, busy8}, 64'd0);
    chk("reset_done", {63'd0, done8}, 64'd0);

    // WIDTH=8 carry cases
    op(8, 64'hFF, 64'h01, 1'b0, mk(64'h00, 1'b1, 1'b0));
    op(8, 64'h7F, 64'h01, 1'b0, mk(64'h80, 1'b0, 1'b1));
    op(8, 64'h80, 64'h80, 1'b1, mk(64'h01, 1'b1, 1'b1));

    // Start during RUN is ignored; previous result held until the final edge
    issue(8, 64'd3, 64'd4, 1'b0, mk(64'd7, 1'b0, 1'b0));
    @(posedge clk); #1 start8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    chk("run_holds_prev_sum", 64'(sum8), 64'h01);
    chk("run_busy", {63'd0, busy8}, 64'd1);
    wait_done(8);
    repeat (12) @(posedge clk);
    #1;

    // Back-to-back with start held high
    issue(8, 64'(bb_a[0]), 64'(bb_b[0]), bb_c[0], mk(64'(bb_s[0]), bb_co[0], bb_ov[0]));
    for (int k = 1; k <= 4; k++) begin
      seen = 1'b0;
      for (int j = 0; j < 20 && !seen; j++) begin
        @(posedge clk); #1;
        if (done8) seen = 1'b1;
        else chk("b2b_busy", {63'd0, busy8}, 64'd1);
      end
      if (!seen) begin
        total++;
        $display("FAIL b2b_timeout: done=0 after 20 cycles, required done=1");
      end
      if (k < 4) issue(8, 64'(bb_a[k]), 64'(bb_b[k]), bb_c[k], mk(64'(bb_s[k]), bb_co[k], bb_ov[k]));
      else start8 = 1'b0;
    end

    // Reset mid-operation: immediate clear, no done
    a8 = 8'd50; b8 = 8'd60; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_sum", 64'(sum8), 64'd0);
    chk("midrst_cout", {63'd0, cout8}, 64'd0);
    chk("midrst_busy", {63'd0, busy8}, 64'd0);
    chk("midrst_done", {63'd0, done8}, 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    op(8, 64'd10, 64'd20, 1'b1, mk(64'd31, 1'b0, 1'b0));

    // WIDTH=4 exhaustive
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          op(4, 64'(ai), 64'(bi), ci[0], model(4, 64'(ai), 64'(bi), ci[0]));

    // WIDTH=1 full-adder truth table
    for (int v = 0; v < 8; v++) begin
      v3 = v[2:0];
      op(1, {63'd0, v3[2]}, {63'd0, v3[1]}, v3[0], model(1, {63'd0, v3[2]}, {63'd0, v3[1]}, v3[0]));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("w8_all_results_seen", 64'(q8.size()), 64'd0);
    chk("w4_all_results_seen", 64'(q4.size()), 64'd0);
    chk("w1_all_results_seen", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
